// File: rtl/acc_en_seq.sv
// acc_en_seq
// Enable sequencer for the accelerator clock/reset controller. Converts
// single-cycle enable/disable requests into a clean core_en_o level, waits
// for the downstream reset-release delay on the way up, and on the way down
// drains the accelerator (idle or timeout) and then holds enable low for a
// cool-down period.
//
// Ports:
//   clk_i           ungated domain clock
//   reset_n_i       asynchronous active-low reset
//   req_en_i        single-cycle start request
//   req_dis_i       single-cycle stop request
//   acc_idle_i      accelerator drained/idle (level, clk_i synchronous)
//   timeout_limit_i stop timeout in cycles, 0 disables the timeout
//   core_en_o       enable to the clock/reset controller
//   stop_req_o      drain request to the accelerator
//   running_o       core is out of reset and operational
//   busy_o          a start/stop transition is in progress
//   timeout_o       sticky: the last stop was forced by timeout
module acc_en_seq #(
  parameter int unsigned RUN_DELAY = 12,
  parameter int unsigned OFF_HOLD  = 4,
  parameter int unsigned TO_W      = 16
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            req_en_i,
  input  logic            req_dis_i,
  input  logic            acc_idle_i,
  input  logic [TO_W-1:0] timeout_limit_i,
  output logic            core_en_o,
  output logic            stop_req_o,
  output logic            running_o,
  output logic            busy_o,
  output logic            timeout_o
);

  // Shared delay counter only ever holds RUN_DELAY-1 or OFF_HOLD-1.
  localparam int unsigned HOLD_MAX = (RUN_DELAY > OFF_HOLD) ? RUN_DELAY : OFF_HOLD;
  localparam int unsigned DLY_W    = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [DLY_W-1:0] RUN_LOAD = DLY_W'(RUN_DELAY - 1);
  localparam logic [DLY_W-1:0] OFF_LOAD = DLY_W'(OFF_HOLD - 1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_STARTING,
    ST_RUN,
    ST_STOPPING,
    ST_COOLDOWN
  } state_e;

  state_e          state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             dis_pend_q, dis_pend_d;
  logic             en_pend_q, en_pend_d;
  logic             timeout_d;

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_OFF;
      dly_q      <= '0;
      to_q       <= '0;
      dis_pend_q <= 1'b0;
      en_pend_q  <= 1'b0;
      core_en_o  <= 1'b0;
      stop_req_o <= 1'b0;
      running_o  <= 1'b0;
      busy_o     <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      to_q       <= to_d;
      dis_pend_q <= dis_pend_d;
      en_pend_q  <= en_pend_d;
      timeout_o  <= timeout_d;
      // Outputs are a pure function of the next state, so they change on
      // the same edge as the state itself.
      core_en_o  <= (state_d == ST_STARTING) || (state_d == ST_RUN) ||
                    (state_d == ST_STOPPING);
      stop_req_o <= (state_d == ST_STOPPING);
      running_o  <= (state_d == ST_RUN) || (state_d == ST_STOPPING);
      busy_o     <= (state_d == ST_STARTING) || (state_d == ST_STOPPING) ||
                    (state_d == ST_COOLDOWN);
    end
  end

  // Next-state, counter and pending-flag logic.
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    to_d       = to_q;
    dis_pend_d = dis_pend_q;
    en_pend_d  = en_pend_q;
    timeout_d  = timeout_o;

    case (state_q)
      ST_OFF: begin
        // A simultaneous enable and disable cancel each other here.
        if (req_en_i && !req_dis_i) begin
          state_d   = ST_STARTING;
          dly_d     = RUN_LOAD;
          timeout_d = 1'b0;
        end
      end

      ST_STARTING: begin
        if (req_dis_i) begin
          dis_pend_d = 1'b1;
        end
        if (dly_q == '0) begin
          state_d = ST_RUN;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end

      ST_RUN: begin
        if (req_dis_i || dis_pend_q) begin
          state_d    = ST_STOPPING;
          to_d       = timeout_limit_i;
          dis_pend_d = 1'b0;
        end
      end

      ST_STOPPING: begin
        // Idle has priority over an expiring timeout in the same cycle.
        if (acc_idle_i) begin
          state_d = ST_COOLDOWN;
          dly_d   = OFF_LOAD;
        end else if (to_q != '0) begin
          to_d = to_q - TO_W'(1);
          if (to_q == TO_W'(1)) begin
            state_d   = ST_COOLDOWN;
            dly_d     = OFF_LOAD;
            timeout_d = 1'b1;
          end
        end
      end

      ST_COOLDOWN: begin
        if (dly_q != '0) begin
          dly_d = dly_q - DLY_W'(1);
          if (req_en_i) begin
            en_pend_d = 1'b1;
          end
        end else if (en_pend_q || req_en_i) begin
          // Restart straight from the end of the hold, as if from OFF.
          state_d   = ST_STARTING;
          dly_d     = RUN_LOAD;
          timeout_d = 1'b0;
          en_pend_d = 1'b0;
        end else begin
          state_d = ST_OFF;
        end
      end

      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

endmodule

// File: tb/tb_acc_en_seq.sv
// Scoreboard bench for acc_en_seq: stimulus pushes the expected output
// vector {core_en, stop_req, running, busy, timeout} after each clock edge;
// a monitor pops and compares on the following falling edge.
module tb_acc_en_seq;

  localparam int unsigned TO_W = 16;

  // Expected output vectors {core_en, stop_req, running, busy, timeout}.
  localparam logic [4:0] V_OFF  = 5'b00000;
  localparam logic [4:0] V_ST   = 5'b10010;
  localparam logic [4:0] V_RUN  = 5'b10100;
  localparam logic [4:0] V_STOP = 5'b11110;
  localparam logic [4:0] V_CD   = 5'b00010;
  localparam logic [4:0] V_TO   = 5'b00001;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic            req_en_i;
  logic            req_dis_i;
  logic            acc_idle_i;
  logic [TO_W-1:0] timeout_limit_i;
  logic            core_en_o;
  logic            stop_req_o;
  logic            running_o;
  logic            busy_o;
  logic            timeout_o;

  typedef struct {
    logic [4:0] exp;
    int         id;
  } sb_t;

  sb_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  step_id  = 0;

  acc_en_seq #(
    .RUN_DELAY(12),
    .OFF_HOLD (4),
    .TO_W     (TO_W)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .req_en_i       (req_en_i),
    .req_dis_i      (req_dis_i),
    .acc_idle_i     (acc_idle_i),
    .timeout_limit_i(timeout_limit_i),
    .core_en_o      (core_en_o),
    .stop_req_o     (stop_req_o),
    .running_o      (running_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: compare outputs against the oldest expected vector.
  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      sb_t e;
      logic [4:0] act;
      e   = exp_q.pop_front();
      act = {core_en_o, stop_req_o, running_o, busy_o, timeout_o};
      n_checks++;
      if (act !== e.exp) begin
        n_errors++;
        $display("FAIL step%0d outputs: got %b expected %b (core_en,stop_req,running,busy,timeout)",
                 e.id, act, e.exp);
      end
    end
  end

  // Drive inputs for one cycle; queue the outputs expected after that edge.
  task automatic step(input logic en, input logic dis, input logic idle,
                      input logic [4:0] exp);
    sb_t e;
    req_en_i   = en;
    req_dis_i  = dis;
    acc_idle_i = idle;
    @(posedge clk_i);
    e.exp = exp;
    e.id  = step_id;
    exp_q.push_back(e);
    step_id++;
    @(negedge clk_i);
  endtask

  // OFF -> STARTING -> RUN, twelve cycles to running.
  task automatic do_start();
    step(1'b1, 1'b0, 1'b0, V_ST);
    repeat (11) step(1'b0, 1'b0, 1'b0, V_ST);
    step(1'b0, 1'b0, 1'b0, V_RUN);
  endtask

  // RUN -> STOPPING -> idle -> four-cycle cool-down -> OFF.
  task automatic do_clean_stop();
    step(1'b0, 1'b1, 1'b0, V_STOP);
    step(1'b0, 1'b0, 1'b1, V_CD);
    repeat (3) step(1'b0, 1'b0, 1'b0, V_CD);
    step(1'b0, 1'b0, 1'b0, V_OFF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i       = 1'b0;
    req_en_i        = 1'b0;
    req_dis_i       = 1'b0;
    acc_idle_i      = 1'b0;
    timeout_limit_i = '0;
    @(negedge clk_i);

    // Reset state, with a request that must be ignored while in reset.
    step(1'b0, 1'b0, 1'b0, V_OFF);
    step(1'b1, 1'b0, 1'b0, V_OFF);
    reset_n_i = 1'b1;

    // Start then clean stop with idle arriving five cycles after the request.
    do_start();
    step(1'b0, 1'b0, 1'b0, V_RUN);
    step(1'b0, 1'b1, 1'b0, V_STOP);
    repeat (4) step(1'b0, 1'b0, 1'b0, V_STOP);
    step(1'b0, 1'b0, 1'b1, V_CD);
    repeat (3) step(1'b0, 1'b0, 1'b0, V_CD);
    step(1'b0, 1'b0, 1'b0, V_OFF);

    // Simultaneous enable and disable in OFF: nothing happens.
    step(1'b1, 1'b1, 1'b0, V_OFF);
    step(1'b0, 1'b0, 1'b0, V_OFF);

    // Timeout of 20 cycles with the accelerator never idle.
    do_start();
    timeout_limit_i = TO_W'(20);
    step(1'b0, 1'b1, 1'b0, V_STOP);
    repeat (19) step(1'b0, 1'b0, 1'b0, V_STOP);
    step(1'b0, 1'b0, 1'b0, V_CD | V_TO);
    repeat (3) step(1'b0, 1'b0, 1'b0, V_CD | V_TO);
    step(1'b0, 1'b0, 1'b0, V_OFF | V_TO);
    step(1'b0, 1'b0, 1'b0, V_OFF | V_TO);
    // Next start clears the sticky timeout flag.
    timeout_limit_i = '0;
    do_start();
    do_clean_stop();

    // Disable during STARTING: RUN for one cycle, then STOPPING.
    step(1'b1, 1'b0, 1'b0, V_ST);
    repeat (4) step(1'b0, 1'b0, 1'b0, V_ST);
    step(1'b0, 1'b1, 1'b0, V_ST);
    repeat (6) step(1'b0, 1'b0, 1'b0, V_ST);
    step(1'b0, 1'b0, 1'b0, V_RUN);
    step(1'b0, 1'b0, 1'b0, V_STOP);
    // Enable during COOLDOWN: straight back to STARTING after the hold.
    step(1'b0, 1'b0, 1'b1, V_CD);
    step(1'b0, 1'b0, 1'b0, V_CD);
    step(1'b1, 1'b0, 1'b0, V_CD);
    step(1'b0, 1'b0, 1'b0, V_CD);
    step(1'b0, 1'b0, 1'b0, V_ST);
    repeat (11) step(1'b0, 1'b0, 1'b0, V_ST);
    step(1'b0, 1'b0, 1'b0, V_RUN);

    // Idle arriving on the timeout-expiry cycle: idle wins, no timeout flag.
    timeout_limit_i = TO_W'(3);
    step(1'b0, 1'b1, 1'b0, V_STOP);
    repeat (2) step(1'b0, 1'b0, 1'b0, V_STOP);
    step(1'b0, 1'b0, 1'b1, V_CD);
    // Enable and disable together in COOLDOWN set the pending enable.
    step(1'b1, 1'b1, 1'b0, V_CD);
    repeat (2) step(1'b0, 1'b0, 1'b0, V_CD);
    step(1'b0, 1'b0, 1'b0, V_ST);
    repeat (11) step(1'b0, 1'b0, 1'b0, V_ST);
    step(1'b0, 1'b0, 1'b0, V_RUN);

    // Asynchronous reset in the middle of STOPPING.
    timeout_limit_i = '0;
    step(1'b0, 1'b1, 1'b0, V_STOP);
    step(1'b0, 1'b0, 1'b0, V_STOP);
    @(posedge clk_i);
    #2;
    reset_n_i = 1'b0;
    begin
      sb_t e;
      e.exp = V_OFF;
      e.id  = step_id;
      exp_q.push_back(e);
      step_id++;
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    // After release the block is OFF and ignores a disable.
    step(1'b0, 1'b1, 1'b0, V_OFF);
    step(1'b0, 1'b0, 1'b1, V_OFF);
    do_start();

    repeat (2) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
